// File: rtl/mem_arbiter.sv
// Two-cycle (ACC, CAP) arbiter sharing one RAM port between an edge-detected CPU strobe bus
// and a level req/ack DMA port. Define ARB_ROUND_ROBIN_EN for alternating priority on contention.
module mem_arbiter (
   input  logic        iClk,
   input  logic        iRst,
   input  logic [19:0] iCpuAddr,
   input  logic [7:0]  iCpuDataW,
   input  logic        iCpuMemR,
   input  logic        iCpuMemW,
   output logic [7:0]  oCpuDataR,
   input  logic        iDmaReq,
   input  logic        iDmaWe,
   input  logic [19:0] iDmaAddr,
   input  logic [7:0]  iDmaDataW,
   output logic        oDmaAck,
   output logic [7:0]  oDmaDataR,
   output logic [19:0] oRamAddr,
   output logic [7:0]  oRamDataW,
   output logic        oRamR,
   output logic        oRamW,
   input  logic [7:0]  iRamDataR,
   output logic        oBusy,
   output logic [1:0]  oDbgState,
   output logic        oDbgLastDma
);

   // DMA handshake: iDmaReq is a level sampled only in IDLE (dropping it earlier withdraws it);
   // each granted access returns exactly one oDmaAck pulse in its CAP cycle.
   typedef enum logic [1:0] {IDLE = 2'd0, ACC = 2'd1, CAP = 2'd2} state_t;
   typedef enum logic {OWN_CPU = 1'b0, OWN_DMA = 1'b1} owner_t;

   state_t      state_q, state_d;
   owner_t      owner_q, owner_d;
   owner_t      last_owner_q, last_owner_d;
   logic        armed_q;
   logic        prev_w_q, prev_r_q;
   logic        cpu_pend_q, cpu_pend_d;
   logic [19:0] cpu_addr_q, cpu_addr_d;
   logic [7:0]  cpu_data_q, cpu_data_d;
   logic        cpu_we_q, cpu_we_d;
   logic        acc_we_q, acc_we_d;
   logic [19:0] ram_addr_q, ram_addr_d;
   logic [7:0]  ram_data_q, ram_data_d;
   logic        ram_r_q, ram_r_d;
   logic        ram_w_q, ram_w_d;
   logic        dma_ack_q, dma_ack_d;
   logic [7:0]  cpu_rdata_q, cpu_rdata_d;
   logic [7:0]  dma_rdata_q, dma_rdata_d;

   logic        rise_w, rise_r, cpu_edge, cpu_req, grant_dma;

   // armed_q masks the first cycle after reset so a strobe already high is not seen as an edge.
   assign rise_w   = armed_q & iCpuMemW & ~prev_w_q;
   assign rise_r   = armed_q & iCpuMemR & ~prev_r_q;
   assign cpu_edge = (rise_w | rise_r) & ~cpu_pend_q;
   assign cpu_req  = cpu_pend_q | cpu_edge;

   always_comb begin
      grant_dma = 1'b0;
      if (iDmaReq) begin
         if (!cpu_req) begin
            grant_dma = 1'b1;
         end
`ifdef ARB_ROUND_ROBIN_EN
         else begin
            grant_dma = (last_owner_q == OWN_CPU);
         end
`endif
      end
   end

   always_ff @(posedge iClk) begin
      if (iRst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_owner_d = last_owner_q;
      cpu_pend_d   = cpu_pend_q;
      cpu_addr_d   = cpu_addr_q;
      cpu_data_d   = cpu_data_q;
      cpu_we_d     = cpu_we_q;
      acc_we_d     = acc_we_q;
      ram_addr_d   = ram_addr_q;
      ram_data_d   = ram_data_q;
      ram_r_d      = 1'b0;
      ram_w_d      = 1'b0;
      dma_ack_d    = 1'b0;
      cpu_rdata_d  = cpu_rdata_q;
      dma_rdata_d  = dma_rdata_q;

      // Write wins when both strobes rise together.
      if (cpu_edge) begin
         cpu_pend_d = 1'b1;
         cpu_addr_d = iCpuAddr;
         cpu_data_d = iCpuDataW;
         cpu_we_d   = rise_w;
      end

      case (state_q)
         IDLE: begin
            if (cpu_req || iDmaReq) begin
               state_d = ACC;
               if (grant_dma) begin
                  owner_d    = OWN_DMA;
                  ram_addr_d = iDmaAddr;
                  ram_data_d = iDmaDataW;
                  acc_we_d   = iDmaWe;
               end else begin
                  owner_d    = OWN_CPU;
                  ram_addr_d = cpu_addr_d;
                  ram_data_d = cpu_data_d;
                  acc_we_d   = cpu_we_d;
               end
               last_owner_d = owner_d;
               ram_w_d      = acc_we_d;
               ram_r_d      = ~acc_we_d;
            end
         end
         ACC: begin
            state_d   = CAP;
            dma_ack_d = (owner_q == OWN_DMA);
         end
         CAP: begin
            state_d = IDLE;
            if (!acc_we_q) begin
               if (owner_q == OWN_DMA) begin
                  dma_rdata_d = iRamDataR;
               end else begin
                  cpu_rdata_d = iRamDataR;
               end
            end
            if (owner_q == OWN_CPU) begin
               cpu_pend_d = 1'b0;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge iClk) begin
      if (iRst) begin
         owner_q      <= OWN_CPU;
         last_owner_q <= OWN_CPU;
         armed_q      <= 1'b0;
         prev_w_q     <= 1'b0;
         prev_r_q     <= 1'b0;
         cpu_pend_q   <= 1'b0;
         cpu_addr_q   <= '0;
         cpu_data_q   <= '0;
         cpu_we_q     <= 1'b0;
         acc_we_q     <= 1'b0;
         ram_addr_q   <= '0;
         ram_data_q   <= '0;
         ram_r_q      <= 1'b0;
         ram_w_q      <= 1'b0;
         dma_ack_q    <= 1'b0;
         cpu_rdata_q  <= '0;
         dma_rdata_q  <= '0;
      end else begin
         owner_q      <= owner_d;
         last_owner_q <= last_owner_d;
         armed_q      <= 1'b1;
         prev_w_q     <= iCpuMemW;
         prev_r_q     <= iCpuMemR;
         cpu_pend_q   <= cpu_pend_d;
         cpu_addr_q   <= cpu_addr_d;
         cpu_data_q   <= cpu_data_d;
         cpu_we_q     <= cpu_we_d;
         acc_we_q     <= acc_we_d;
         ram_addr_q   <= ram_addr_d;
         ram_data_q   <= ram_data_d;
         ram_r_q      <= ram_r_d;
         ram_w_q      <= ram_w_d;
         dma_ack_q    <= dma_ack_d;
         cpu_rdata_q  <= cpu_rdata_d;
         dma_rdata_q  <= dma_rdata_d;
      end
   end

   assign oRamAddr    = ram_addr_q;
   assign oRamDataW   = ram_data_q;
   assign oRamR       = ram_r_q;
   assign oRamW       = ram_w_q;
   assign oDmaAck     = dma_ack_q;
   assign oCpuDataR   = cpu_rdata_q;
   // RAM data is forwarded during the ack cycle so oDmaDataR is already valid alongside oDmaAck.
   assign oDmaDataR   = (state_q == CAP && owner_q == OWN_DMA && !acc_we_q) ? iRamDataR : dma_rdata_q;
   assign oBusy       = (state_q != IDLE);
   assign oDbgState   = state_q;
   assign oDbgLastDma = (last_owner_q == OWN_DMA);

endmodule
